// File: rtl/conv_stream_tx.sv
// Convolver transmit feeder: ingress FIFO plus a per-frame FSM that streams
// KERNEL_SIZE^2 kernel beats, then pixel_count image beats. Optional macro: CONV_TX_FLUSH_PAD_EN.
module conv_stream_tx #(
  parameter int BITS        = 9,
  parameter int KERNEL_SIZE = 3,
  parameter int IMG_LENGTH  = 128,
  parameter int FIFO_DEPTH  = 16,
  parameter int CNT_W       = 16
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             start,
  input  logic [CNT_W-1:0] pixel_count,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [BITS-1:0]  in_data,
  output logic             kernel_write_en,
  output logic [BITS-1:0]  kernel_out,
  output logic             img_write_en,
  output logic [BITS-1:0]  img_out,
  output logic             busy,
  output logic             done
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [CNT_W-1:0] K_LAST = CNT_W'(KERNEL_SIZE * KERNEL_SIZE - 1);

  if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0 || IMG_LENGTH < 1) begin : g_bad_cfg
    $error("conv_stream_tx: FIFO_DEPTH must be a power of two >= 2 and IMG_LENGTH >= 1");
  end

`ifdef CONV_TX_FLUSH_PAD_EN
  localparam logic [CNT_W-1:0] PAD_LAST = CNT_W'(IMG_LENGTH * (KERNEL_SIZE - 1) + KERNEL_SIZE - 1);
  typedef enum logic [2:0] {ST_IDLE, ST_KERNEL, ST_IMAGE, ST_PAD, ST_DONE} state_t;
  localparam state_t ST_AFTER = ST_PAD;
`else
  typedef enum logic [2:0] {ST_IDLE, ST_KERNEL, ST_IMAGE, ST_DONE} state_t;
  localparam state_t ST_AFTER = ST_DONE;
`endif

  // Ingress FIFO: extra pointer bit distinguishes full from empty.
  logic [BITS-1:0] mem [FIFO_DEPTH];
  logic [AW:0]     wr_ptr_reg;
  logic [AW:0]     rd_ptr_reg;
  logic            empty;
  logic            full;
  logic            push;
  logic            pop;
  logic [BITS-1:0] pop_word;

  state_t           state_reg;
  logic [CNT_W-1:0] cnt_reg;
  logic [CNT_W-1:0] limit_reg;

  assign empty    = (wr_ptr_reg == rd_ptr_reg);
  assign full     = (wr_ptr_reg[AW] != rd_ptr_reg[AW]) &&
                    (wr_ptr_reg[AW-1:0] == rd_ptr_reg[AW-1:0]);
  assign in_ready = reset_n && !full;
  assign push     = in_valid && in_ready;
  assign pop      = ((state_reg == ST_KERNEL) || (state_reg == ST_IMAGE)) && !empty;
  assign pop_word = mem[rd_ptr_reg[AW-1:0]];

  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr_reg[AW-1:0]] <= in_data;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
    end else begin
      if (push) wr_ptr_reg <= wr_ptr_reg + 1'b1;
      if (pop)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
    end
  end

  // done is raised on the edge that enters DONE, so it is high for the whole DONE cycle.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_reg       <= ST_IDLE;
      cnt_reg         <= '0;
      limit_reg       <= '0;
      kernel_write_en <= 1'b0;
      kernel_out      <= '0;
      img_write_en    <= 1'b0;
      img_out         <= '0;
      busy            <= 1'b0;
      done            <= 1'b0;
    end else begin
      kernel_write_en <= 1'b0;
      img_write_en    <= 1'b0;
      done            <= 1'b0;
      case (state_reg)
        ST_IDLE: begin
          if (start) begin
            limit_reg <= pixel_count;
            cnt_reg   <= '0;
            busy      <= 1'b1;
            state_reg <= ST_KERNEL;
          end
        end
        ST_KERNEL: begin
          if (pop) begin
            kernel_write_en <= 1'b1;
            kernel_out      <= pop_word;
            if (cnt_reg == K_LAST) begin
              cnt_reg <= '0;
              if (limit_reg == '0) begin
                state_reg <= ST_AFTER;
                done      <= (ST_AFTER == ST_DONE);
              end else begin
                state_reg <= ST_IMAGE;
              end
            end else begin
              cnt_reg <= cnt_reg + 1'b1;
            end
          end
        end
        ST_IMAGE: begin
          if (pop) begin
            img_write_en <= 1'b1;
            img_out      <= pop_word;
            if (cnt_reg == limit_reg - CNT_W'(1)) begin
              cnt_reg   <= '0;
              state_reg <= ST_AFTER;
              done      <= (ST_AFTER == ST_DONE);
            end else begin
              cnt_reg <= cnt_reg + 1'b1;
            end
          end
        end
`ifdef CONV_TX_FLUSH_PAD_EN
        ST_PAD: begin
          // Zero beats push the final window through the convolver; FIFO is untouched.
          img_write_en <= 1'b1;
          img_out      <= '0;
          if (cnt_reg == PAD_LAST) begin
            cnt_reg   <= '0;
            state_reg <= ST_DONE;
            done      <= 1'b1;
          end else begin
            cnt_reg <= cnt_reg + 1'b1;
          end
        end
`endif
        ST_DONE: begin
          busy      <= 1'b0;
          state_reg <= ST_IDLE;
        end
        default: begin
          busy      <= 1'b0;
          state_reg <= ST_IDLE;
        end
      endcase
    end
  end

endmodule
